vga_sync_receiver: RTL and testbench

- Receiver end of the VGA timing interface. Takes hsync/vsync from a VGA source, recovers the pixel position and the visible-area flag, and measures line and frame lengths.
- Asserts locked once the incoming timing matches the configured mode for LOCK_FRAMES consecutive frames.
- Sits on the capture side of the icevga board and feeds downstream pixel sampling and framebuffer logic. Runs on the global PLL clock and advances on a pixel-rate enable.

---
 rtl/vga_sync_receiver.sv | 185 ++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: synchronizes hsync/vsync, recovers the pixel position,
// measures line and frame lengths and locks onto the configured mode.
module vga_sync_receiver #(
  parameter int unsigned H_SYNC      = 128,
  parameter int unsigned H_BP        = 88,
  parameter int unsigned H_VIS       = 800,
  parameter int unsigned H_TOTAL     = 1056,
  parameter int unsigned V_SYNC      = 4,
  parameter int unsigned V_BP        = 23,
  parameter int unsigned V_VIS       = 600,
  parameter int unsigned V_TOTAL     = 628,
  parameter logic        H_POL       = 1'b1,
  parameter logic        V_POL       = 1'b1,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines
);

  localparam logic [10:0] HV_LO  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HV_HI  = 11'(H_SYNC + H_BP + H_VIS - 1);
  localparam logic [9:0]  VV_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VV_HI  = 10'(V_SYNC + V_BP + V_VIS - 1);
  localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [10:0] H_MAX  = 11'h7FF;
  localparam logic [9:0]  V_MAX  = 10'h3FF;

  logic        hs_meta_r, hs_sync_r, vs_meta_r, vs_sync_r;
  logic        hs_prev_r, vs_prev_r;
  logic [10:0] hcount_r;
  logic [9:0]  vcount_r;
  logic        h_seen_r, v_seen_r, line_bad_r;
  logic [3:0]  good_cnt_r;

  logic        hs_s, vs_s, hs_edge_s, vs_edge_s, timeout_s;
  logic [10:0] meas_s, hcount_s, line_len_s, pix_x_s;
  logic [9:0]  vcount_s, frame_lines_s, pix_y_s;
  logic        h_seen_s, v_seen_s, line_bad_s, locked_s, de_s;
  logic [3:0]  good_cnt_s;

  // Internal syncs are active-high regardless of the source polarity.
  assign hs_s = hs_sync_r ^ ~H_POL;
  assign vs_s = vs_sync_r ^ ~V_POL;

  // Two-flop synchronizer, clocked every clk independent of pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_meta_r <= 1'b0;
      hs_sync_r <= 1'b0;
      vs_meta_r <= 1'b0;
      vs_sync_r <= 1'b0;
    end else begin
      hs_meta_r <= hsync_in;
      hs_sync_r <= hs_meta_r;
      vs_meta_r <= vsync_in;
      vs_sync_r <= vs_meta_r;
    end
  end

  // Next-state for counters, measurements and the lock qualifier.
  always_comb begin
    hs_edge_s     = hs_s & ~hs_prev_r;
    vs_edge_s     = vs_s & ~vs_prev_r;
    meas_s        = hcount_r + 11'd1;
    hcount_s      = hcount_r;
    vcount_s      = vcount_r;
    line_len_s    = line_len;
    frame_lines_s = frame_lines;
    h_seen_s      = h_seen_r;
    v_seen_s      = v_seen_r;
    line_bad_s    = line_bad_r;
    good_cnt_s    = good_cnt_r;
    locked_s      = locked;

    if (hs_edge_s) begin
      line_len_s = meas_s;
      hcount_s   = 11'd0;
      h_seen_s   = 1'b1;
      if (!h_seen_r || (meas_s != H_TOT)) begin
        line_bad_s = 1'b1;
      end else begin
        line_bad_s = line_bad_r;
      end
      if (vcount_r != V_MAX) begin
        vcount_s = vcount_r + 10'd1;
      end else begin
        vcount_s = vcount_r;
      end
    end else if (hcount_r != H_MAX) begin
      hcount_s = hcount_r + 11'd1;
    end else begin
      hcount_s = hcount_r;
    end

    // A coincident hs edge starts line 0, so vcount is forced to 0 here.
    if (vs_edge_s) begin
      frame_lines_s = vcount_r;
      vcount_s      = 10'd0;
      if (v_seen_r && !line_bad_s && (vcount_r == V_TOT)) begin
        if (good_cnt_r != LOCK_N) begin
          good_cnt_s = good_cnt_r + 4'd1;
        end else begin
          good_cnt_s = good_cnt_r;
        end
        if (good_cnt_s == LOCK_N) begin
          locked_s = 1'b1;
        end else begin
          locked_s = locked;
        end
      end else begin
        good_cnt_s = 4'd0;
        locked_s   = 1'b0;
      end
      line_bad_s = 1'b0;
      v_seen_s   = 1'b1;
    end else begin
      frame_lines_s = frame_lines;
    end

    timeout_s  = (hcount_s == H_MAX);
    locked_s   = locked_s & ~timeout_s;
    h_seen_s   = h_seen_s & ~timeout_s;
    v_seen_s   = v_seen_s & ~timeout_s;
    good_cnt_s = timeout_s ? 4'd0 : good_cnt_s;

    de_s = locked_s && (hcount_s >= HV_LO) && (hcount_s <= HV_HI)
                    && (vcount_s >= VV_LO) && (vcount_s <= VV_HI);
    if (de_s) begin
      pix_x_s = hcount_s - HV_LO;
      pix_y_s = vcount_s - VV_LO;
    end else begin
      pix_x_s = 11'd0;
      pix_y_s = 10'd0;
    end
  end

  // State and outputs advance only on pixel-rate enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_prev_r   <= 1'b0;
      vs_prev_r   <= 1'b0;
      hcount_r    <= 11'd0;
      vcount_r    <= 10'd0;
      h_seen_r    <= 1'b0;
      v_seen_r    <= 1'b0;
      line_bad_r  <= 1'b0;
      good_cnt_r  <= 4'd0;
      locked      <= 1'b0;
      de          <= 1'b0;
      pix_x       <= 11'd0;
      pix_y       <= 10'd0;
      line_len    <= 11'd0;
      frame_lines <= 10'd0;
    end else if (pix_en) begin
      hs_prev_r   <= hs_s;
      vs_prev_r   <= vs_s;
      hcount_r    <= hcount_s;
      vcount_r    <= vcount_s;
      h_seen_r    <= h_seen_s;
      v_seen_r    <= v_seen_s;
      line_bad_r  <= line_bad_s;
      good_cnt_r  <= good_cnt_s;
      locked      <= locked_s;
      de          <= de_s;
      pix_x       <= pix_x_s;
      pix_y       <= pix_y_s;
      line_len    <= line_len_s;
      frame_lines <= frame_lines_s;
    end else begin
      hs_prev_r <= hs_prev_r;
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a reduced video mode and a
// pixel-coordinate reference model driven by a randomized timing source.
module tb_vga_sync_receiver;

  localparam int H_SYNC  = 3;
  localparam int H_BP    = 2;
  localparam int H_VIS   = 12;
  localparam int H_TOTAL = 20;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 1;
  localparam int V_VIS   = 6;
  localparam int V_TOTAL = 11;
  localparam int LOCK    = 2;
  localparam int HV      = H_SYNC + H_BP;
  localparam int VV      = V_SYNC + V_BP;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        locked, de;
  logic [10:0] pix_x, line_len;
  logic [9:0]  pix_y, frame_lines;

  int total = 0;
  int bad = 0;

  // Reference model state, in stream terms (pixel/line coordinates).
  int good_m, lines_since, prev_len, exp_ll, exp_fl, exp_x, exp_y;
  bit exp_locked, exp_de, v_seen_m, h_seen_m, bad_acc;

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_VIS(H_VIS), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_VIS(V_VIS), .V_TOTAL(V_TOTAL),
    .H_POL(1'b1), .V_POL(1'b1), .LOCK_FRAMES(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .locked(locked), .de(de), .pix_x(pix_x), .pix_y(pix_y),
    .line_len(line_len), .frame_lines(frame_lines)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("locked", locked, exp_locked);
    chk("de", de, exp_de);
    chk("pix_x", pix_x, exp_x);
    chk("pix_y", pix_y, exp_y);
    chk("line_len", line_len, exp_ll);
    chk("frame_lines", frame_lines, exp_fl);
  endtask

  task automatic model_reset();
    good_m = 0; lines_since = 0; prev_len = 1;
    exp_ll = 0; exp_fl = 0; exp_x = 0; exp_y = 0;
    exp_locked = 1'b0; exp_de = 1'b0;
    v_seen_m = 1'b0; h_seen_m = 1'b0; bad_acc = 1'b0;
  endtask

  // Pins change just after a clk edge; pix_en fires after at least 2 idle clks.
  task automatic send_pixel(input bit hs, input bit vs);
    hsync_in = hs;
    vsync_in = vs;
    repeat ($urandom_range(2, 5)) begin
      @(posedge clk); #1;
    end
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  // Expected outputs after the receiver has consumed pixel p of line l.
  task automatic model_step(input int l, input int p);
    int m;
    if (p == 0) begin
      m = ((prev_len - 1 > 2047) ? 2047 : prev_len - 1) + 1;
      exp_ll = m % 2048;
      if (!h_seen_m || exp_ll != H_TOTAL) bad_acc = 1'b1;
      h_seen_m = 1'b1;
      lines_since++;
    end
    if (l == 0 && p == 1) begin
      exp_fl = lines_since;
      if (v_seen_m && !bad_acc && lines_since == V_TOTAL) begin
        if (good_m < LOCK) good_m++;
        if (good_m == LOCK) exp_locked = 1'b1;
      end else begin
        good_m = 0;
        exp_locked = 1'b0;
      end
      bad_acc = 1'b0;
      v_seen_m = 1'b1;
      lines_since = 0;
    end
    if (p == 2047) begin
      exp_locked = 1'b0; good_m = 0; h_seen_m = 1'b0; v_seen_m = 1'b0;
    end
    exp_de = exp_locked && p >= HV && p < HV + H_VIS && l >= VV && l < VV + V_VIS;
    exp_x = exp_de ? p - HV : 0;
    exp_y = exp_de ? l - VV : 0;
  endtask

  task automatic hold_test();
    for (int i = 0; i < 100; i++) begin
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (i % 10 == 9) check_all();
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all();
    reset = 1'b0;
  endtask

  // mode: 0 plain, 1 pix_en hold mid-frame, 3 reset mid-line
  task automatic run_frame(input int n, input int bad_line, input int bad_len, input int mode);
    int len;
    for (int l = 0; l < n; l++) begin
      len = (l == bad_line) ? bad_len : H_TOTAL;
      for (int p = 0; p < len; p++) begin
        send_pixel(p < H_SYNC,
                   (l == 0 && p >= 1) || (l > 0 && l < V_SYNC) || (l == V_SYNC && p == 0));
        model_step(l, p);
        check_all();
        if (mode == 1 && l == 4 && p == 8) hold_test();
        if (mode == 3 && l == 5 && p == 10) begin
          reset_pulse();
          return;
        end
      end
      prev_len = len;
    end
  endtask

  initial begin
    int r, n, bl, blen;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_all();
    reset = 1'b0;

    // Clean stream: lock rises at the third vs edge.
    for (int f = 0; f < 4; f++) run_frame(V_TOTAL, -1, 0, 0);
    chk("locked_clean", locked, 1);

    // One line one pixel long, then recovery.
    run_frame(V_TOTAL, 5, H_TOTAL + 1, 0);
    for (int f = 0; f < 3; f++) run_frame(V_TOTAL, -1, 0, 0);

    // One extra line in a frame.
    run_frame(V_TOTAL + 1, -1, 0, 0);
    for (int f = 0; f < 3; f++) run_frame(V_TOTAL, -1, 0, 0);

    // Randomized mix of clean and perturbed frames.
    for (int f = 0; f < 8; f++) begin
      r = $urandom_range(0, 9);
      n = V_TOTAL; bl = -1; blen = 0;
      if (r >= 6 && r < 8) begin
        bl = $urandom_range(0, V_TOTAL - 1);
        blen = H_TOTAL - 2 + $urandom_range(0, 3);
        if (blen >= H_TOTAL) blen++;
      end else if (r >= 8) begin
        n = V_TOTAL - 2 + $urandom_range(0, 4);
      end
      run_frame(n, bl, blen, 0);
    end
    for (int f = 0; f < 3; f++) run_frame(V_TOTAL, -1, 0, 0);

    // pix_en held low while locked, then hsync stuck low until timeout.
    run_frame(V_TOTAL, -1, 0, 1);
    run_frame(V_TOTAL, 6, 2060, 0);
    for (int f = 0; f < 4; f++) run_frame(V_TOTAL, -1, 0, 0);
    chk("locked_after_timeout", locked, 1);

    // Reset mid-line, then relock from scratch.
    run_frame(V_TOTAL, -1, 0, 3);
    for (int f = 0; f < 4; f++) run_frame(V_TOTAL, -1, 0, 0);
    chk("locked_after_reset", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
